// File: rtl/wallace_final_adder_pkg.sv
// Shared multiplier definitions: default operand geometry and the final-adder FSM state type.
package wallace_final_adder_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int SLICE_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } fa_state_e;

endpackage

// File: rtl/wallace_final_adder_cpa_slice.sv
// Combinational SLICE-bit ripple-carry adder used one slice per cycle by the final adder.
module cpa_slice #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] sum,
    output logic             cout
);

    always_comb begin : ripple
        logic c;
        sum = '0;
        c   = cin;
        for (int i = 0; i < SLICE; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/wallace_final_adder.sv
// Multi-cycle carry-propagate adder that resolves the Wallace tree SUM/CARRY pair, SLICE bits per cycle.
module wallace_final_adder
    import wallace_final_adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SLICE = SLICE_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_sum,
    input  logic [WIDTH-1:0] in_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_product,
    output logic             out_cout
);

    localparam int NSLICES = WIDTH / SLICE;
    localparam int KW      = (NSLICES > 1) ? $clog2(NSLICES) : 1;
    localparam logic [KW-1:0] KLAST = KW'(NSLICES - 1);

    fa_state_e        state, state_next;
    logic [WIDTH-1:0] op_sum, op_carry, work, work_next;
    logic [KW-1:0]    k;
    logic             carry_q;
    logic [SLICE-1:0] slice_a, slice_b, slice_sum;
    logic             slice_cout;
    logic             in_fire, out_fire, last_slice;

    assign in_fire    = in_valid && in_ready;
    assign out_fire   = out_valid && out_ready;
    assign last_slice = (k == KLAST);

    // Pick operand slice k and merge the new sum slice into the working result.
    always_comb begin
        slice_a   = '0;
        slice_b   = '0;
        work_next = work;
        for (int i = 0; i < NSLICES; i++) begin
            if (k == KW'(i)) begin
                slice_a                        = op_sum[i*SLICE +: SLICE];
                slice_b                        = op_carry[i*SLICE +: SLICE];
                work_next[i*SLICE +: SLICE]    = slice_sum;
            end
        end
    end

    cpa_slice #(.SLICE(SLICE)) u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = ADD;
            end
            ADD: begin
                if (last_slice) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // The visible product only changes when the last slice completes, so it holds through IDLE and ADD.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_sum      <= '0;
            op_carry    <= '0;
            work        <= '0;
            k           <= '0;
            carry_q     <= 1'b0;
            out_product <= '0;
            out_cout    <= 1'b0;
        end else if (in_fire) begin
            op_sum   <= in_sum;
            op_carry <= in_carry;
            k        <= '0;
            carry_q  <= 1'b0;
        end else if (state == ADD) begin
            work    <= work_next;
            carry_q <= slice_cout;
            k       <= k + KW'(1);
            if (last_slice) begin
                out_product <= work_next;
                out_cout    <= slice_cout;
            end
        end
    end

endmodule

// File: doc/wallace_final_adder.md
WALLACE_FINAL_ADDER -- requirements
Module: wallace_final_adder

Interface
REQ-001 The block SHALL have exactly one clock, clk, and one synchronous active-high reset, rst.
REQ-002 Parameter WIDTH, default 16, SHALL set the operand and result width in bits.
REQ-003 Parameter SLICE, default 4, SHALL set the bits added per cycle; WIDTH SHALL be an integer multiple of SLICE.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  SUM/CARRY pair from the Wallace tree reduction stage is valid.
REQ-007 in_ready  output  1  block can accept a pair this cycle.
REQ-008 in_sum  input  WIDTH  signed sum vector from the reduction stage.
REQ-009 in_carry  input  WIDTH  signed carry vector from the reduction stage, already weight-aligned by the reduction stage (no shift applied here).
REQ-010 out_valid  output  1  product is valid.
REQ-011 out_ready  input  1  downstream accepts product.
REQ-012 out_product  output  WIDTH  signed (in_sum + in_carry) mod 2^WIDTH.
REQ-013 out_cout  output  1  carry out of bit WIDTH-1, informational.

Function
REQ-014 A transfer in SHALL occur on a rising edge where in_valid and in_ready are both 1; a transfer out SHALL occur where out_valid and out_ready are both 1.
REQ-015 The FSM SHALL have three states: IDLE, ADD, DONE.
REQ-016 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-017 IDLE -> ADD on an input transfer; in_sum and in_carry SHALL be captured into operand registers, the slice counter cleared, and the carry register cleared.
REQ-018 In ADD, each cycle SHALL add slice k (bits k*SLICE+SLICE-1 : k*SLICE) of both operands plus the carry register, write the SLICE-bit result into the matching bits of the result register, store the slice carry-out, and increment k.
REQ-019 ADD -> DONE after the slice with k = WIDTH/SLICE - 1 is processed; out_cout SHALL equal that slice's carry-out.
REQ-020 Latency SHALL be WIDTH/SLICE cycles (4 at defaults): out_valid rises on the edge WIDTH/SLICE cycles after the input transfer edge.
REQ-021 In DONE, out_product and out_cout SHALL hold stable while out_ready is 0 (arbitrary stall length).
REQ-022 DONE -> IDLE on an output transfer; a new input SHALL NOT be accepted in the same cycle (in_ready is 0 in DONE), giving a throughput of one result per WIDTH/SLICE + 2 cycles at best.
REQ-023 in_valid asserted outside IDLE SHALL be ignored and the upstream stage SHALL hold its data until in_ready is 1.
REQ-024 Arithmetic SHALL be modulo 2^WIDTH; two's-complement wrap SHALL NOT be flagged other than by out_cout.
REQ-025 out_product SHALL retain its last value in IDLE and ADD; only out_valid qualifies it.

Reset
REQ-026 On rst = 1 at a rising edge, the state SHALL become IDLE, in_ready SHALL be 1 the following cycle, and out_valid, out_product, out_cout, the slice counter and the carry register SHALL be 0.
REQ-027 rst SHALL take priority over any simultaneous transfer; an addition in progress (ADD or DONE) SHALL be discarded without producing out_valid.

Structure
REQ-028 WIDTH and SLICE defaults and the three-value FSM state type SHALL live in the shared multiplier package used by the reduction stage.
REQ-029 The per-cycle slice adder SHALL be a separate combinational sub-module, cpa_slice (SLICE-bit ripple adder with carry-in and carry-out); wallace_final_adder SHALL instantiate exactly one.

Verification
REQ-030 Carry ripple: in_sum=16'h00FF, in_carry=16'h0001 -> out_product=16'h0100, out_cout=0, out_valid 4 cycles after accept.
REQ-031 Signed result: in_sum=16'hFFF0, in_carry=16'h0001 -> out_product=16'hFFF1 (-15), out_cout=0.
REQ-032 Wrap: in_sum=16'hFFFF, in_carry=16'h0001 -> out_product=16'h0000, out_cout=1.
REQ-033 Backpressure: out_ready held 0 for 10 cycles after out_valid -> out_product stable, in_ready 0 throughout; in_valid with new data during the stall is not accepted; the result transfers on the cycle out_ready rises.
REQ-034 Reset mid-operation: rst asserted 2 cycles after accepting 16'h1234+16'h4321 -> out_valid never asserts for it, in_ready=1 the cycle after reset; the next pair 16'h0003+16'h0004 -> 16'h0007.
REQ-035 Randomised back-to-back: 1000 random pairs with random valid/ready gaps -> every out_product equals (in_sum+in_carry) mod 2^16 in issue order, none lost or duplicated.
